// File: rtl/word_pkg.sv
// Shared types and constants for the word loader: FSM states, the NUL
// terminator, the default delimiter and the delimiter test.
package word_pkg;

    localparam int unsigned CHAR_W = 8;

    typedef logic [CHAR_W-1:0] char_t;

    localparam char_t NUL   = 8'h00;
    localparam char_t DELIM = 8'h20;

    typedef enum logic [2:0] {
        FILL   = 3'd0,
        DRAIN  = 3'd1,
        TERM   = 3'd2,
        MATCH  = 3'd3,
        REPORT = 3'd4
    } wl_state_t;

    // NUL always ends a word, in addition to the configured delimiter.
    function automatic logic is_delim(input char_t c, input char_t delim);
        return (c == delim) || (c == NUL);
    endfunction

endpackage

// File: rtl/word_loader.sv
// Splits a byte stream into words, writes each word NUL-terminated into the
// input-word SRAM, runs the matcher on it and returns one result per word.
module word_loader #(
    parameter int unsigned            ADDR_WIDTH = 4,
    parameter int unsigned            DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0]  DELIM      = DATA_WIDTH'(word_pkg::DELIM),
    parameter int unsigned            MAX_LEN    = 2**ADDR_WIDTH - 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    output logic                  match_cs,
    input  logic                  match_done,
    input  logic                  match_found,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  res_found,
    output logic [ADDR_WIDTH-1:0] res_len,
    output logic                  res_ovf
);
    import word_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] LEN_MAX = ADDR_WIDTH'(MAX_LEN);

    wl_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] len_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic                  ovf_q;
    logic                  found_q;

    logic                  delim_c;
    logic                  take_c;
    logic                  fill_wr_c;
    logic [ADDR_WIDTH-1:0] wr_base_c;

    assign delim_c   = is_delim(CHAR_W'(in_data), CHAR_W'(DELIM));
    assign take_c    = in_valid && ((state_q == FILL) || (state_q == DRAIN));
    assign fill_wr_c = (state_q == FILL) && in_valid && !delim_c && (len_q < LEN_MAX);
    // The first character's address comes straight from base_addr; base_q only
    // holds it from the following cycle on.
    assign wr_base_c = (len_q == '0) ? base_addr : base_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: begin
                if (take_c) begin
                    if (delim_c) begin
                        if (len_q != '0) state_d = TERM;
                    end else if (len_q == LEN_MAX) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN:   if (take_c && delim_c) state_d = REPORT;
            TERM:    state_d = MATCH;
            MATCH:   if (match_done) state_d = REPORT;
            REPORT:  if (res_ready) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        match_cs  = 1'b0;
        res_valid = 1'b0;
        sram_we   = 1'b0;
        sram_addr = '0;
        sram_din  = '0;
        case (state_q)
            FILL: begin
                in_ready = 1'b1;
                if (fill_wr_c) begin
                    sram_we   = 1'b1;
                    sram_addr = wr_base_c + len_q;
                    sram_din  = in_data;
                end
            end
            DRAIN:  in_ready = 1'b1;
            TERM: begin
                sram_we   = 1'b1;
                sram_addr = base_q + len_q;
                sram_din  = DATA_WIDTH'(NUL);
            end
            MATCH:  match_cs  = 1'b1;
            REPORT: res_valid = 1'b1;
            default: ;
        endcase
    end

    // Word length, overflow flag, base address and match result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q   <= '0;
            base_q  <= '0;
            ovf_q   <= 1'b0;
            found_q <= 1'b0;
        end else begin
            if (fill_wr_c) begin
                len_q <= len_q + ADDR_WIDTH'(1);
                if (len_q == '0) base_q <= base_addr;
            end
            if (take_c && (state_q == FILL) && !delim_c && (len_q == LEN_MAX)) begin
                ovf_q <= 1'b1;
            end
            if (take_c && (state_q == DRAIN) && delim_c) begin
                found_q <= 1'b0;
            end
            if ((state_q == MATCH) && match_done) begin
                found_q <= match_found;
            end
            if ((state_q == REPORT) && res_ready) begin
                len_q <= '0;
                ovf_q <= 1'b0;
            end
        end
    end

    assign res_found = found_q;
    assign res_len   = len_q;
    assign res_ovf   = ovf_q;

endmodule

// File: tb/tb_word_loader.sv
// Directed bench for word_loader with an SRAM model and a matcher model whose
// done latency and found value are set per word.
module tb_word_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [3:0] base_addr;
    logic       sram_we;
    logic [3:0] sram_addr;
    logic [7:0] sram_din;
    logic       match_cs;
    logic       match_done;
    logic       match_found;
    logic       res_valid;
    logic       res_ready;
    logic       res_found;
    logic [3:0] res_len;
    logic       res_ovf;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [16];
    int         we_cnt = 0;
    int         cs_rises = 0;
    int         res_cnt = 0;
    logic       cs_prev = 1'b0;
    int         cs_cnt;
    int         done_lat = 0;
    logic       found_cfg = 1'b0;

    always #5 clk = ~clk;

    word_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .base_addr  (base_addr),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_din   (sram_din),
        .match_cs   (match_cs),
        .match_done (match_done),
        .match_found(match_found),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_found  (res_found),
        .res_len    (res_len),
        .res_ovf    (res_ovf)
    );

    always @(posedge clk) begin
        if (sram_we) begin
            mem[sram_addr] <= sram_din;
            we_cnt <= we_cnt + 1;
        end
        cs_prev <= match_cs;
        if (match_cs && !cs_prev) cs_rises <= cs_rises + 1;
        if (rst_n && res_valid && res_ready) res_cnt <= res_cnt + 1;
    end

    // Matcher model: done after done_lat cycles of cs.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        cs_cnt <= 0;
        else if (match_cs) cs_cnt <= cs_cnt + 1;
        else               cs_cnt <= 0;
    end
    assign match_done  = match_cs && (cs_cnt == done_lat);
    assign match_found = found_cfg;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            cycle();
            n++;
        end
        if (!in_ready) chk("in_ready_wait", 32'(in_ready), 32'd1);
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic wait_result(input string tag, input logic f, input logic [3:0] l, input logic o);
        int n = 0;
        while (!res_valid && n < 100) begin
            cycle();
            n++;
        end
        if (!res_valid) begin
            chk({tag, "_timeout"}, 32'(res_valid), 32'd1);
        end else begin
            chk({tag, "_found"}, 32'(res_found), 32'(f));
            chk({tag, "_len"},   32'(res_len),   32'(l));
            chk({tag, "_ovf"},   32'(res_ovf),   32'(o));
            chk({tag, "_cs_low"}, 32'(match_cs), 32'd0);
            res_ready = 1'b1;
            cycle();
            res_ready = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int we0, cs0, res0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        base_addr = 4'd0;
        res_ready = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'hee;
        repeat (3) cycle();

        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_match_cs",  32'(match_cs),  32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_sram_we",   32'(sram_we),   32'd0);
        chk("rst_res_len",   32'(res_len),   32'd0);
        rst_n = 1'b1;
        cycle();

        // "cat " at base 0, found, done after 2 extra cycles
        found_cfg = 1'b1;
        done_lat  = 2;
        base_addr = 4'd0;
        send_str("cat ");
        chk("cat_term_we",   32'(sram_we),   32'd1);
        chk("cat_term_addr", 32'(sram_addr), 32'd3);
        chk("cat_term_din",  32'(sram_din),  32'd0);
        chk("cat_term_rdy",  32'(in_ready),  32'd0);
        cycle();
        chk("cat_match_cs",  32'(match_cs),  32'd1);
        wait_result("cat", 1'b1, 4'd3, 1'b0);
        chk("cat_mem0", 32'(mem[0]), 32'h63);
        chk("cat_mem1", 32'(mem[1]), 32'h61);
        chk("cat_mem2", 32'(mem[2]), 32'h74);
        chk("cat_mem3", 32'(mem[3]), 32'h00);
        chk("cat_cs_rises", 32'(cs_rises), 32'd1);
        chk("cat_res_cnt",  32'(res_cnt),  32'd1);

        // "  \0dog\0" at base 4, not found
        found_cfg = 1'b0;
        done_lat  = 0;
        base_addr = 4'd4;
        send_str("  ");
        send_byte(8'h00);
        chk("lead_no_res",  32'(res_valid), 32'd0);
        chk("lead_in_rdy",  32'(in_ready),  32'd1);
        send_str("dog");
        send_byte(8'h00);
        wait_result("dog", 1'b0, 4'd3, 1'b0);
        chk("dog_mem4", 32'(mem[4]), 32'h64);
        chk("dog_mem6", 32'(mem[6]), 32'h67);
        chk("dog_mem7", 32'(mem[7]), 32'h00);
        chk("dog_res_cnt", 32'(res_cnt), 32'd2);

        // 17 chars overflow: 15 writes, no matcher run
        found_cfg = 1'b1;
        base_addr = 4'd0;
        we0 = we_cnt;
        cs0 = cs_rises;
        for (int i = 0; i < 17; i++) send_byte(8'h7a);
        send_byte(8'h20);
        wait_result("ovf", 1'b0, 4'd15, 1'b1);
        chk("ovf_writes",   32'(we_cnt - we0),   32'd15);
        chk("ovf_no_cs",    32'(cs_rises - cs0), 32'd0);
        chk("ovf_mem14",    32'(mem[14]), 32'h7a);

        // Address wrap: base 14, "ab ", done on first cs cycle
        found_cfg = 1'b1;
        done_lat  = 0;
        base_addr = 4'd14;
        send_str("ab ");
        wait_result("wrap", 1'b1, 4'd2, 1'b0);
        chk("wrap_mem14", 32'(mem[14]), 32'h61);
        chk("wrap_mem15", 32'(mem[15]), 32'h62);
        chk("wrap_mem0",  32'(mem[0]),  32'h00);

        // Backpressure: result held while "x" is offered
        found_cfg = 1'b0;
        done_lat  = 1;
        base_addr = 4'd10;
        send_str("q ");
        for (int n = 0; n < 100 && !res_valid; n++) cycle();
        res0 = res_cnt;
        in_valid  = 1'b1;
        in_data   = 8'h78;
        base_addr = 4'd8;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready",  32'(in_ready),  32'd0);
            chk("bp_res_valid", 32'(res_valid), 32'd1);
            chk("bp_res_len",   32'(res_len),   32'd1);
            cycle();
        end
        res_ready = 1'b1;
        cycle();
        res_ready = 1'b0;
        chk("bp_freed", 32'(in_ready), 32'd1);
        chk("bp_res_cnt", 32'(res_cnt - res0), 32'd1);
        send_byte(8'h78);
        send_byte(8'h20);
        wait_result("x", 1'b0, 4'd1, 1'b0);
        chk("x_mem8", 32'(mem[8]), 32'h78);
        chk("x_mem9", 32'(mem[9]), 32'h00);

        // Reset pulse during MATCH
        found_cfg = 1'b1;
        done_lat  = 10;
        base_addr = 4'd2;
        send_str("hi ");
        cycle();
        chk("rstm_cs_before", 32'(match_cs), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstm_cs",        32'(match_cs),  32'd0);
        chk("rstm_res_valid", 32'(res_valid), 32'd0);
        chk("rstm_sram_we",   32'(sram_we),   32'd0);
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("rstm_in_ready", 32'(in_ready), 32'd1);
        chk("rstm_res_len",  32'(res_len),  32'd0);
        done_lat  = 0;
        base_addr = 4'd0;
        send_str("ok ");
        wait_result("ok", 1'b1, 4'd2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
